// File: rtl/myproject_mac_pipe.sv
`default_nettype none
// ============================================================================
// Module      : myproject_mac_pipe
// Description : Pipelined signed multiply-accumulate. Beats are tagged
//               first/last and each vector emits a single dot product.
//               Optional macro MAC_SAT_EN enables accumulator saturation
//               and the sticky ovf flag.
// Revision    : 1.0 - initial release
// ============================================================================
module myproject_mac_pipe #(
    parameter int DIN0_WIDTH  = 16,
    parameter int DIN1_WIDTH  = 11,
    parameter bit DIN1_SIGNED = 1'b0,
    parameter int NUM_STAGE   = 2,
    parameter int ACC_WIDTH   = 32
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        ce,
    input  logic                        in_valid,
    input  logic                        in_first,
    input  logic                        in_last,
    input  logic signed [DIN0_WIDTH-1:0] din0,
    input  logic [DIN1_WIDTH-1:0]       din1,
    output logic                        out_valid,
    output logic signed [ACC_WIDTH-1:0] dout,
    output logic                        busy,
    output logic                        ovf
);

    localparam int P = DIN0_WIDTH + DIN1_WIDTH;

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_ACCUM = 1'b1
    } state_t;

    // Both operands are extended to P bits; the low P bits of the product
    // are exact because the true product always fits in P signed bits.
    logic                d1_sx;
    logic [P-1:0]        op0_w;
    logic [P-1:0]        op1_w;
    logic signed [P-1:0] prod_w;

    assign d1_sx  = DIN1_SIGNED ? din1[DIN1_WIDTH-1] : 1'b0;
    assign op0_w  = {{DIN1_WIDTH{din0[DIN0_WIDTH-1]}}, din0};
    assign op1_w  = {{DIN0_WIDTH{d1_sx}}, din1};
    assign prod_w = op0_w * op1_w;

    logic [NUM_STAGE-1:0] stg_vld;
    logic [NUM_STAGE-1:0] stg_fst;
    logic [NUM_STAGE-1:0] stg_lst;
    logic [NUM_STAGE-1:0] stg_vld_d;
    logic signed [P-1:0]  stg_prod [NUM_STAGE];

    for (genvar i = 0; i < NUM_STAGE; i++) begin : g_stage
        logic                vld_d;
        logic                fst_d;
        logic                lst_d;
        logic signed [P-1:0] prod_d;
        logic                vld_q;
        logic                fst_q;
        logic                lst_q;
        logic signed [P-1:0] prod_q;

        if (i == 0) begin : g_head
            assign vld_d  = in_valid;
            assign fst_d  = in_first;
            assign lst_d  = in_last;
            assign prod_d = prod_w;
        end else begin : g_body
            assign vld_d  = stg_vld[i-1];
            assign fst_d  = stg_fst[i-1];
            assign lst_d  = stg_lst[i-1];
            assign prod_d = stg_prod[i-1];
        end

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                vld_q  <= 1'b0;
                fst_q  <= 1'b0;
                lst_q  <= 1'b0;
                prod_q <= '0;
            end else if (ce) begin
                vld_q  <= vld_d;
                fst_q  <= fst_d;
                lst_q  <= lst_d;
                prod_q <= prod_d;
            end
        end

        assign stg_vld[i]   = vld_q;
        assign stg_fst[i]   = fst_q;
        assign stg_lst[i]   = lst_q;
        assign stg_prod[i]  = prod_q;
        assign stg_vld_d[i] = vld_d;
    end

    logic                        tail_vld;
    logic                        tail_fst;
    logic                        tail_lst;
    logic signed [P-1:0]         tail_prod;
    logic signed [ACC_WIDTH-1:0] prod_ext;

    assign tail_vld  = stg_vld[NUM_STAGE-1];
    assign tail_fst  = stg_fst[NUM_STAGE-1];
    assign tail_lst  = stg_lst[NUM_STAGE-1];
    assign tail_prod = stg_prod[NUM_STAGE-1];
    assign prod_ext  = ACC_WIDTH'(tail_prod);

    state_t                      state_q;
    state_t                      state_d;
    logic signed [ACC_WIDTH-1:0] acc_q;
    logic signed [ACC_WIDTH-1:0] acc_d;
    logic signed [ACC_WIDTH-1:0] add_w;
    logic signed [ACC_WIDTH-1:0] dout_q;
    logic                        emit_q;
    logic                        emit_d;
    logic                        out_valid_q;
    logic                        busy_q;
    logic                        busy_d;

`ifdef MAC_SAT_EN
    localparam logic signed [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

    logic signed [ACC_WIDTH:0] sum_w;
    logic                      clamp_w;
    logic                      sovf_q;
    logic                      sovf_d;
    logic                      ovf_q;

    // One guard bit: the two top bits disagree exactly when the sum overflowed.
    assign sum_w   = (ACC_WIDTH+1)'(acc_q) + (ACC_WIDTH+1)'(prod_ext);
    assign clamp_w = sum_w[ACC_WIDTH] ^ sum_w[ACC_WIDTH-1];
    assign add_w   = !clamp_w ? sum_w[ACC_WIDTH-1:0]
                              : (sum_w[ACC_WIDTH] ? ACC_MIN : ACC_MAX);
`else
    assign add_w   = acc_q + prod_ext;
`endif

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        emit_d  = 1'b0;
`ifdef MAC_SAT_EN
        sovf_d  = sovf_q;
`endif
        if (tail_vld) begin
            // A first beat while a vector is open restarts the sum silently.
            if ((state_q == S_IDLE) || tail_fst) begin
                acc_d  = prod_ext;
`ifdef MAC_SAT_EN
                sovf_d = 1'b0;
`endif
            end else begin
                acc_d  = add_w;
`ifdef MAC_SAT_EN
                sovf_d = sovf_q | clamp_w;
`endif
            end
            if (tail_lst) begin
                emit_d  = 1'b1;
                state_d = S_IDLE;
            end else begin
                state_d = S_ACCUM;
            end
        end
        busy_d = (|stg_vld_d) || (state_d == S_ACCUM) || emit_d;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            acc_q       <= '0;
            emit_q      <= 1'b0;
            out_valid_q <= 1'b0;
            dout_q      <= '0;
            busy_q      <= 1'b0;
`ifdef MAC_SAT_EN
            sovf_q      <= 1'b0;
            ovf_q       <= 1'b0;
`endif
        end else if (ce) begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            emit_q      <= emit_d;
            out_valid_q <= emit_q;
            busy_q      <= busy_d;
`ifdef MAC_SAT_EN
            sovf_q      <= sovf_d;
`endif
            if (emit_q) begin
                dout_q <= acc_q;
`ifdef MAC_SAT_EN
                ovf_q  <= sovf_q;
`endif
            end
        end
    end

    assign out_valid = out_valid_q;
    assign dout      = dout_q;
    assign busy      = busy_q;
`ifdef MAC_SAT_EN
    assign ovf       = ovf_q;
`else
    assign ovf       = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_myproject_mac_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_myproject_mac_pipe
// Description : Scoreboard bench for myproject_mac_pipe: default, signed-din1
//               and 28-bit accumulator instances; honours MAC_SAT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_myproject_mac_pipe;

    localparam int LAT = 3;  // NUM_STAGE + 1 ce-enabled edges

`ifdef MAC_SAT_EN
    localparam longint T4_DOUT = -134217728;
    localparam bit     T4_OVF  = 1'b1;
`else
    localparam longint T4_DOUT = -66945024;
    localparam bit     T4_OVF  = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;
    logic ce;
    always #5 clk = ~clk;

    logic               v [3];
    logic               f [3];
    logic               l [3];
    logic signed [15:0] a [3];
    logic [10:0]        b [3];
    logic               ov [3];
    logic               bz [3];
    logic               of [3];
    logic signed [31:0] d0;
    logic signed [31:0] d1;
    logic signed [27:0] d2;
    logic signed [31:0] dv [3];

    assign dv[0] = d0;
    assign dv[1] = d1;
    assign dv[2] = {{4{d2[27]}}, d2};

    myproject_mac_pipe u_def (
        .clk(clk), .reset(reset), .ce(ce),
        .in_valid(v[0]), .in_first(f[0]), .in_last(l[0]),
        .din0(a[0]), .din1(b[0]),
        .out_valid(ov[0]), .dout(d0), .busy(bz[0]), .ovf(of[0])
    );

    myproject_mac_pipe #(.DIN1_SIGNED(1'b1)) u_sgn (
        .clk(clk), .reset(reset), .ce(ce),
        .in_valid(v[1]), .in_first(f[1]), .in_last(l[1]),
        .din0(a[1]), .din1(b[1]),
        .out_valid(ov[1]), .dout(d1), .busy(bz[1]), .ovf(of[1])
    );

    myproject_mac_pipe #(.ACC_WIDTH(28)) u_nar (
        .clk(clk), .reset(reset), .ce(ce),
        .in_valid(v[2]), .in_first(f[2]), .in_last(l[2]),
        .din0(a[2]), .din1(b[2]),
        .out_valid(ov[2]), .dout(d2), .busy(bz[2]), .ovf(of[2])
    );

    typedef struct {
        int                 k;
        logic signed [31:0] d;
        logic               o;
        int                 c;
    } exp_t;

    exp_t sb [$];
    int   n_cmp  = 0;
    int   n_bad  = 0;
    int   ce_cnt = 0;
    bit   edge_ce = 1'b0;

    task automatic check(string nm, logic signed [63:0] act, logic signed [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0d, required %0d", nm, act, req);
        end
    endtask

    always @(posedge clk) begin
        edge_ce <= reset && ce;
        if (reset && ce) ce_cnt <= ce_cnt + 1;
    end

    // A new result appears only after a ce-enabled edge; held pulses are skipped.
    always @(negedge clk) begin
        if (edge_ce) begin
            for (int k = 0; k < 3; k++) begin
                if (ov[k]) begin
                    if (sb.size() == 0) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL unexpected_out inst%0d: got dout=%0d, required no output", k, dv[k]);
                    end else begin
                        exp_t e;
                        e = sb.pop_front();
                        check($sformatf("out_inst inst%0d", k), k, e.k);
                        check($sformatf("dout inst%0d", k), dv[k], e.d);
                        check($sformatf("ovf inst%0d", k), of[k], e.o);
                        check($sformatf("latency inst%0d", k), ce_cnt, e.c);
                    end
                end
            end
        end
    end

    task automatic beat(int k, bit fi, bit la, int x, int y, longint ed = 0, bit eo = 1'b0);
        for (int j = 0; j < 3; j++) v[j] = 1'b0;
        v[k] = 1'b1;
        f[k] = fi;
        l[k] = la;
        a[k] = 16'(x);
        b[k] = 11'(y);
        ce   = 1'b1;
        if (la) begin
            exp_t e;
            e.k = k;
            e.d = 32'(ed);
            e.o = eo;
            e.c = ce_cnt + 1 + LAT;
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        v[k] = 1'b0;
    endtask

    task automatic idle(int n, bit c);
        for (int j = 0; j < 3; j++) v[j] = 1'b0;
        ce = c;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
        ce = 1'b1;
    endtask

    initial begin
        for (int k = 0; k < 3; k++) begin
            v[k] = 1'b0; f[k] = 1'b0; l[k] = 1'b0; a[k] = '0; b[k] = '0;
        end
        ce    = 1'b0;
        reset = 1'b1;
        #1 reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            check($sformatf("rst_out_valid inst%0d", k), ov[k], 0);
            check($sformatf("rst_dout inst%0d", k), dv[k], 0);
            check($sformatf("rst_busy inst%0d", k), bz[k], 0);
            check($sformatf("rst_ovf inst%0d", k), of[k], 0);
        end
        reset = 1'b1;
        idle(2, 1'b1);

        // Basic three-term dot product
        beat(0, 1, 0, 100, 3);
        beat(0, 0, 0, -20, 7);
        beat(0, 0, 1, 5, 2047, 10395);
        check("busy_open", bz[0], 1);
        idle(8, 1'b1);
        check("busy_drained", bz[0], 0);

        // Single-beat extremes, unsigned and signed din1
        beat(0, 1, 1, -32768, 2047, -67076096);
        idle(1, 1'b1);
        beat(1, 1, 1, -32768, 2047, 32768);
        idle(1, 1'b1);
        beat(1, 1, 0, 10, 2045);
        beat(1, 0, 1, -4, 5, -50);
        idle(6, 1'b1);

        // Bubbles and a ce gap mid-stream
        beat(0, 1, 0, 100, 3);
        idle(1, 1'b1);
        beat(0, 0, 0, -20, 7);
        idle(3, 1'b0);
        idle(1, 1'b1);
        beat(0, 0, 1, 5, 2047, 10395);
        idle(2, 1'b0);
        idle(6, 1'b1);

        // ce low while the result pulse is presented
        beat(0, 1, 1, 1, 5, 5);
        idle(3, 1'b1);
        ce = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("hold_out_valid", ov[0], 1);
            check("hold_dout", dv[0], 5);
            @(posedge clk);
            #1;
        end
        idle(2, 1'b1);
        check("pulse_ends", ov[0], 0);

        // 28-bit accumulator overflow, then a fresh vector
        beat(2, 1, 0, -32768, 2047);
        beat(2, 0, 0, -32768, 2047);
        beat(2, 0, 0, -32768, 2047);
        beat(2, 0, 0, -32768, 2047);
        beat(2, 0, 1, -32768, 2047, T4_DOUT, T4_OVF);
        beat(2, 1, 1, 1, 1, 1, 1'b0);
        idle(8, 1'b1);

        // Asynchronous reset aborts an open vector
        beat(0, 1, 0, 9, 9);
        beat(0, 0, 0, 9, 9);
        #2 reset = 1'b0;
        #3;
        check("abort_busy", bz[0], 0);
        check("abort_dout", dv[0], 0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        idle(1, 1'b1);
        beat(0, 1, 1, 4, 4, 16);
        idle(6, 1'b1);

        // Back-to-back vectors, open vector dropped by a new first
        beat(0, 1, 1, 2, 3, 6);
        beat(0, 1, 0, 1, 1);
        beat(0, 1, 1, 7, 7, 49);
        idle(6, 1'b1);

        // Vector started in IDLE without a first flag
        beat(0, 0, 0, 3, 3);
        beat(0, 0, 1, 2, 2, 13);
        idle(6, 1'b1);

        for (int i = 0; i < 50 && sb.size() > 0; i++) @(posedge clk);
        if (sb.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL missing_outputs: got %0d pending, required 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
